imem_boot_loader: RTL and testbench

Synthesisable successor to the processor's hand-written program-load testbench. Streams a sparse program into the instruction memory over a valid/ready port. Optionally pre-fills every word with a no-op first, then holds the core in reset until started. While the core runs, it watches the PC for a halt address or a cycle budget and reports completion. Sits between a host/bench stream source and the Processor's instruction-memory write port and reset input.

---
 rtl/imem_boot_loader_pkg.sv | 18 +
 rtl/imem_boot_loader_if.sv | 20 ++
 rtl/imem_boot_loader_run_monitor.sv | 70 +++++++
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// risc_boot_pkg: shared types and constants for the instruction-memory boot
// loader. Holds the loader state encoding and the no-op word used to sweep
// the memory before a program is streamed in.
package risc_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_DONE
  } boot_state_e;

  // Encoding of the processor's no-op instruction.
  localparam logic [31:0] NOP_WORD = 32'h6800_0000;

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: program-word stream from a host to the boot loader.
//   valid  word present            ready  loader accepts the word
//   addr   target word address     data   instruction word
//   last   final word of the program
// master = stream source (host/bench), slave = boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, addr, data, last, input ready);
  modport slave  (input valid, addr, data, last, output ready);

endinterface

// File: rtl/imem_boot_loader_run_monitor.sv
// run_monitor: watches a running core. Counts cycles spent running
// (saturating), compares the PC against the halt address and the count
// against the cycle budget, and keeps sticky done/timeout flags.
// Ports:
//   clk, reset (async, active-low)
//   clear        load pulse: zero the counter and flags
//   run          core is in the RUN state this cycle
//   run_cycles   budget, 0 = unlimited
//   halt_pc      PC value meaning "program finished"
//   core_pc      current processor PC
//   finish       combinational: run ends at the coming edge
//   done         sticky completion flag
//   timeout      sticky "ended on budget" flag
//   cycle_count  cycles counted while running
module run_monitor
  import risc_boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic [ADDR_W-1:0] halt_pc,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              finish,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count
);

  logic             halt_hit;
  logic             budget_hit;
  logic             done_reg;
  logic             timeout_reg;
  logic [CYC_W-1:0] cycle_count_reg;

  assign halt_hit   = (core_pc == halt_pc);
  // The count seen now is the number of cycles already completed, so the
  // budget is used up when it equals run_cycles-1 at this edge.
  assign budget_hit = (run_cycles != '0) &&
                      (cycle_count_reg == (run_cycles - CYC_W'(1)));
  assign finish     = run && (halt_hit || budget_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      cycle_count_reg <= '0;
    end else if (clear) begin
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      cycle_count_reg <= '0;
    end else if (run) begin
      if (cycle_count_reg != '1)
        cycle_count_reg <= cycle_count_reg + CYC_W'(1);
      if (finish) begin
        done_reg    <= 1'b1;
        timeout_reg <= !halt_hit;  // halt has priority over the budget
      end
    end
  end

  assign done        = done_reg;
  assign timeout     = timeout_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a sparse program into the processor's instruction
// memory, optionally sweeping every word with a no-op first, holds the core
// in reset until started, then watches the run for halt or budget expiry.
// Ports:
//   clk, reset (async, active-low)
//   load         pulse: (re)start loading from any state
//   s            program stream (slave side of imem_boot_loader_if)
//   start        pulse: release the core (only honoured when ARMED)
//   run_cycles   cycle budget, 0 = unlimited
//   halt_pc      PC marking program end;  core_pc  processor PC
//   imem_we/imem_addr/imem_wdata  registered instruction-memory write port
//   core_reset   active-high reset to the processor
//   busy         CLEAR, LOAD or RUN
//   done/timeout sticky run outcome;  cycle_count  cycles spent running
//   load_count   words accepted in the current load
module imem_boot_loader
  import risc_boot_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 8,
  parameter int CYC_W         = 16,
  parameter bit CLEAR_ON_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  imem_boot_loader_if.slave s,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic [ADDR_W-1:0] halt_pc,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   load_count
);

  localparam int LC_W = ADDR_W + 1;

  boot_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] clear_addr_reg, clear_addr_next;
  logic              s_ready_reg, s_ready_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [DATA_W-1:0] imem_wdata_reg, imem_wdata_next;
  logic              core_reset_reg, core_reset_next;
  logic              busy_reg, busy_next;
  logic [LC_W-1:0]   load_count_reg, load_count_next;
  logic              handshake;
  logic              run_finish;

  // s_ready_reg is high exactly while in LOAD; a load pulse takes priority
  // over a word offered in the same cycle.
  assign handshake = s.valid && s_ready_reg && !load;

  run_monitor #(
    .ADDR_W (ADDR_W),
    .CYC_W  (CYC_W)
  ) u_run_monitor (
    .clk         (clk),
    .reset       (reset),
    .clear       (load),
    .run         (state_reg == ST_RUN),
    .run_cycles  (run_cycles),
    .halt_pc     (halt_pc),
    .core_pc     (core_pc),
    .finish      (run_finish),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = CLEAR_ON_LOAD ? ST_CLEAR : ST_LOAD;
    end else begin
      case (state_reg)
        ST_CLEAR: if (clear_addr_reg == '1)  state_next = ST_LOAD;
        ST_LOAD:  if (handshake && s.last)   state_next = ST_ARMED;
        ST_ARMED: if (start)                 state_next = ST_RUN;
        ST_RUN:   if (run_finish)            state_next = ST_DONE;
        default:  state_next = state_reg;
      endcase
    end
  end

  // Output logic: values every registered output takes after this edge.
  always_comb begin
    s_ready_next    = (state_next == ST_LOAD);
    core_reset_next = !((state_next == ST_RUN) || (state_next == ST_DONE));
    busy_next       = (state_next == ST_CLEAR) || (state_next == ST_LOAD) ||
                      (state_next == ST_RUN);
    clear_addr_next = clear_addr_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
    load_count_next = load_count_reg;

    if (state_next == ST_CLEAR) begin
      // Entering CLEAR (or restarting it) begins the sweep at address 0;
      // staying in CLEAR advances one word per cycle.
      clear_addr_next = (state_reg == ST_CLEAR && !load) ?
                        clear_addr_reg + ADDR_W'(1) : '0;
      imem_we_next    = 1'b1;
      imem_addr_next  = clear_addr_next;
      imem_wdata_next = DATA_W'(NOP_WORD);
    end else if (handshake) begin
      imem_we_next    = 1'b1;
      imem_addr_next  = s.addr;
      imem_wdata_next = s.data;
    end

    if (load)
      load_count_next = '0;
    else if (handshake && load_count_reg != '1)
      load_count_next = load_count_reg + LC_W'(1);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_addr_reg <= '0;
      s_ready_reg    <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      core_reset_reg <= 1'b1;
      busy_reg       <= 1'b0;
      load_count_reg <= '0;
    end else begin
      clear_addr_reg <= clear_addr_next;
      s_ready_reg    <= s_ready_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      core_reset_reg <= core_reset_next;
      busy_reg       <= busy_next;
      load_count_reg <= load_count_next;
    end
  end

  assign s.ready    = s_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign core_reset = core_reset_reg;
  assign busy       = busy_reg;
  assign load_count = load_count_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed, self-checking bench for imem_boot_loader
// with ADDR_W=5 and CLEAR_ON_LOAD=1. Captures the memory write port into a
// local array and checks outputs 1 time unit after each rising edge.
module tb_imem_boot_loader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [31:0] NOP = 32'h6800_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic [AW-1:0] halt_pc = '0;
  logic [AW-1:0] core_pc = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [AW:0]   load_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] tb_mem [0:31];
  logic [AW-1:0] prog_addr [0:7];
  logic [DW-1:0] prog_data [0:7];

  imem_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  imem_boot_loader #(
    .DATA_W(DW), .ADDR_W(AW), .CYC_W(CW), .CLEAR_ON_LOAD(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .s           (s_if),
    .start       (start),
    .run_cycles  (run_cycles),
    .halt_pc     (halt_pc),
    .core_pc     (core_pc),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in
  always @(posedge clk)
    if (imem_we === 1'b1) tb_mem[imem_addr] <= imem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic l);
    s_if.valid = 1'b1;
    s_if.addr  = a;
    s_if.data  = d;
    s_if.last  = l;
    tick();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    $display("load word addr=%0d data=%h last=%0b", a, d, l);
  endtask

  // Full sweep plus a one-word program, leaving the loader ARMED.
  task automatic reload_one();
    pulse_load();
    repeat (32) tick();
    send_word('0, NOP, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", s_if.ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL rst_imem_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin n_err++; $display("FAIL rst_imem_bus: got %h/%h want 0/0", imem_addr, imem_wdata); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL rst_flags: got busy=%b done=%b to=%b want 000", busy, done, timeout); end
    n_cmp++; if (cycle_count !== 16'd0 || load_count !== 6'd0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d want 0/0", cycle_count, load_count); end
    reset = 1'b1;
    tick();
    // start while IDLE must be ignored
    pulse_start();
    tick();
    n_cmp++; if (core_reset !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL idle_start_ignored: got core_reset=%b busy=%b want 1 0", core_reset, busy); end
    $display("reset checks done");
  endtask

  task automatic test_clear_load();
    pulse_load();
    n_cmp++; if (busy !== 1'b1 || s_if.ready !== 1'b0) begin n_err++; $display("FAIL clear_busy: got busy=%b ready=%b want 1 0", busy, s_if.ready); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (imem_we !== 1'b1 || imem_addr !== AW'(i) || imem_wdata !== NOP) begin
        n_err++;
        $display("FAIL clear_write_%0d: got we=%b addr=%0d data=%h want 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, NOP);
      end
      tick();
    end
    n_cmp++; if (s_if.ready !== 1'b1 || imem_we !== 1'b0) begin n_err++; $display("FAIL load_ready: got ready=%b we=%b want 1 0", s_if.ready, imem_we); end
    for (int k = 0; k < 8; k++) begin
      send_word(prog_addr[k], prog_data[k], k == 7);
      n_cmp++;
      if (imem_we !== 1'b1 || imem_addr !== prog_addr[k] || imem_wdata !== prog_data[k]) begin
        n_err++;
        $display("FAIL load_write_%0d: got we=%b addr=%0d data=%h want 1 %0d %h", k, imem_we, imem_addr, imem_wdata, prog_addr[k], prog_data[k]);
      end
    end
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL armed_ready: got %b want 0", s_if.ready); end
    tick();
    n_cmp++; if (tb_mem[2] !== NOP || tb_mem[3] !== NOP || tb_mem[5] !== NOP) begin n_err++; $display("FAIL mem_gaps: got %h %h %h want %h", tb_mem[2], tb_mem[3], tb_mem[5], NOP); end
    n_cmp++; if (tb_mem[0] !== 32'h4C00000C || tb_mem[17] !== 32'h88000005 || tb_mem[19] !== 32'h68000000) begin n_err++; $display("FAIL mem_prog: got %h %h %h want 4c00000c 88000005 68000000", tb_mem[0], tb_mem[17], tb_mem[19]); end
    n_cmp++; if (load_count !== 6'd8) begin n_err++; $display("FAIL load_count: got %0d want 8", load_count); end
    n_cmp++; if (core_reset !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL armed_state: got core_reset=%b busy=%b want 1 0", core_reset, busy); end
  endtask

  task automatic test_run_halt();
    halt_pc = 5'd20;
    run_cycles = '0;
    core_pc = '0;
    pulse_start();
    n_cmp++; if (core_reset !== 1'b0 || busy !== 1'b1 || cycle_count !== 16'd0) begin n_err++; $display("FAIL run_entry: got core_reset=%b busy=%b cnt=%0d want 0 1 0", core_reset, busy, cycle_count); end
    for (int i = 1; i <= 20; i++) begin
      core_pc = AW'(i);
      if (i == 20) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL halt_early: got done=%b want 0", done); end
      end
      tick();
    end
    core_pc = '0;
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_err++; $display("FAIL halt_flags: got done=%b to=%b want 1 0", done, timeout); end
    n_cmp++; if (cycle_count !== 16'd20) begin n_err++; $display("FAIL halt_count: got %0d want 20", cycle_count); end
    n_cmp++; if (core_reset !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL done_state: got core_reset=%b busy=%b want 0 0", core_reset, busy); end
    pulse_start();
    tick();
    n_cmp++; if (cycle_count !== 16'd20 || done !== 1'b1 || core_reset !== 1'b0) begin n_err++; $display("FAIL done_frozen: got cnt=%0d done=%b core_reset=%b want 20 1 0", cycle_count, done, core_reset); end
    $display("run halt: cycles=%0d", cycle_count);
  endtask

  task automatic test_timeout();
    reload_one();
    run_cycles = 16'd10;
    halt_pc = 5'd31;
    core_pc = '0;
    pulse_start();
    for (int j = 1; j <= 10; j++) begin
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL budget_early_%0d: got done=%b want 0", j, done); end
      tick();
    end
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b1) begin n_err++; $display("FAIL budget_flags: got done=%b to=%b want 1 1", done, timeout); end
    n_cmp++; if (cycle_count !== 16'd10) begin n_err++; $display("FAIL budget_count: got %0d want 10", cycle_count); end
    $display("run budget: cycles=%0d", cycle_count);
  endtask

  task automatic test_tie();
    reload_one();
    n_cmp++; if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 16'd0) begin n_err++; $display("FAIL reload_cleared: got done=%b to=%b cnt=%0d want 0 0 0", done, timeout, cycle_count); end
    run_cycles = 16'd5;
    halt_pc = 5'd7;
    core_pc = '0;
    pulse_start();
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) core_pc = 5'd7;
      tick();
    end
    core_pc = '0;
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_err++; $display("FAIL tie_flags: got done=%b to=%b want 1 0", done, timeout); end
    n_cmp++; if (cycle_count !== 16'd5) begin n_err++; $display("FAIL tie_count: got %0d want 5", cycle_count); end
    $display("run tie: cycles=%0d", cycle_count);
  endtask

  task automatic test_abort();
    reload_one();
    run_cycles = '0;
    halt_pc = 5'd31;
    core_pc = '0;
    pulse_start();
    repeat (3) tick();
    n_cmp++; if (cycle_count !== 16'd3 || core_reset !== 1'b0) begin n_err++; $display("FAIL abort_pre: got cnt=%0d core_reset=%b want 3 0", cycle_count, core_reset); end
    pulse_load();
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL abort_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 16'd0) begin n_err++; $display("FAIL abort_cleared: got done=%b to=%b cnt=%0d want 0 0 0", done, timeout, cycle_count); end
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 5'd0 || busy !== 1'b1 || s_if.ready !== 1'b0) begin n_err++; $display("FAIL abort_clear: got we=%b addr=%0d busy=%b ready=%b want 1 0 1 0", imem_we, imem_addr, busy, s_if.ready); end
    $display("run aborted by load");
  endtask

  task automatic test_reset_mid_load();
    repeat (32) tick();
    n_cmp++; if (s_if.ready !== 1'b1) begin n_err++; $display("FAIL midload_ready: got %b want 1", s_if.ready); end
    s_if.valid = 1'b1;
    s_if.addr  = 5'd4;
    s_if.data  = 32'h1111_1111;
    s_if.last  = 1'b0;
    tick();
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 5'd4) begin n_err++; $display("FAIL midload_write: got we=%b addr=%0d want 1 4", imem_we, imem_addr); end
    s_if.addr = 5'd6;
    s_if.data = 32'hDEAD_BEEF;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (imem_we !== 1'b0 || s_if.ready !== 1'b0) begin n_err++; $display("FAIL async_reset: got we=%b ready=%b want 0 0", imem_we, s_if.ready); end
    n_cmp++; if (core_reset !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset_state: got core_reset=%b busy=%b want 1 0", core_reset, busy); end
    tick();
    tick();
    n_cmp++; if (load_count !== 6'd0) begin n_err++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
    n_cmp++; if (tb_mem[4] !== NOP || tb_mem[6] !== NOP) begin n_err++; $display("FAIL reset_no_write: got %h %h want %h", tb_mem[4], tb_mem[6], NOP); end
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (s_if.ready !== 1'b0 || imem_we !== 1'b0) begin n_err++; $display("FAIL idle_ignore_valid: got ready=%b we=%b want 0 0", s_if.ready, imem_we); end
    s_if.valid = 1'b0;
    $display("reset mid-load done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_addr[0] = 5'd0;  prog_data[0] = 32'h4C00000C;
    prog_addr[1] = 5'd1;  prog_data[1] = 32'h4C400001;
    prog_addr[2] = 5'd4;  prog_data[2] = 32'h48800000;
    prog_addr[3] = 5'd8;  prog_data[3] = 32'h10448000;
    prog_addr[4] = 5'd9;  prog_data[4] = 32'h0C880001;
    prog_addr[5] = 5'd13; prog_data[5] = 32'h2C080001;
    prog_addr[6] = 5'd17; prog_data[6] = 32'h88000005;
    prog_addr[7] = 5'd19; prog_data[7] = 32'h68000000;
    s_if.valid = 1'b0;
    s_if.addr  = '0;
    s_if.data  = '0;
    s_if.last  = 1'b0;

    test_reset();
    test_clear_load();
    test_run_halt();
    test_timeout();
    test_tie();
    test_abort();
    test_reset_mid_load();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
